// File: rtl/wavetable_voice_scheduler.sv
// ---------------------------------------------------------------------------
// wavetable_voice_scheduler
//
// Shares one wavetable ROM bank (four shapes behind a select mux) among
// NUM_VOICES oscillator voices. Each sample tick starts a frame. The frame
// visits every voice in order. For each voice it drives the phase-derived
// address and the shape select, waits ROM_LAT cycles, adds the returned
// sample to a mix accumulator and advances the voice phase. At the end of the
// frame it emits one mixed sample.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   tick                sample-rate strobe; starts a frame when idle
//   cfg_we/voice/field  host register write: 0=tuning word, 1=shape/enable,
//   cfg_wdata           2=phase load, 3=ignored. Field 1 uses [1:0]=shape,
//                       [2]=enable
//   overrun_clr         clears the sticky overrun flag
//   rom_addr, rom_sel   registered address / shape select to the ROM bank
//   rom_data            ROM sample, valid ROM_LAT cycles after rom_addr
//   mix_out, mix_valid  signed frame mix and its one-cycle strobe
//   busy                a frame is in progress
//   overrun             sticky; a tick arrived while busy and was dropped
// ---------------------------------------------------------------------------

// Per-voice register set: tuning word, shape, enable and phase accumulator.
// cfg_hit: host write addressed to this voice.
// adv:     scheduler captured this voice's sample; step the phase.
module wavetable_voice #(
    parameter int PHASE_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_hit,
    input  logic [1:0]         cfg_field,
    input  logic [PHASE_W-1:0] cfg_wdata,
    input  logic               adv,
    output logic [PHASE_W-1:0] phase,
    output logic [1:0]         shape,
    output logic               en
);
    logic [PHASE_W-1:0] ftw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ftw   <= '0;
            shape <= '0;
            en    <= 1'b0;
            phase <= '0;
        end else begin
            if (cfg_hit && cfg_field == 2'd0)
                ftw <= cfg_wdata;
            if (cfg_hit && cfg_field == 2'd1) begin
                shape <= cfg_wdata[1:0];
                en    <= cfg_wdata[2];
            end
            // A host phase load beats the scheduler's increment on the same edge.
            if (cfg_hit && cfg_field == 2'd2)
                phase <= cfg_wdata;
            else if (adv)
                phase <= phase + ftw;   // wraps modulo 2^PHASE_W
        end
    end
endmodule

module wavetable_voice_scheduler #(
    parameter  int NUM_VOICES = 4,
    parameter  int ROM_LAT    = 1,
    parameter  int ADDR_W     = 12,
    parameter  int DATA_W     = 16,
    parameter  int PHASE_W    = 32,
    localparam int VIDX_W     = $clog2(NUM_VOICES),
    localparam int MIX_W      = DATA_W + VIDX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               cfg_we,
    input  logic [VIDX_W-1:0]  cfg_voice,
    input  logic [1:0]         cfg_field,
    input  logic [PHASE_W-1:0] cfg_wdata,
    input  logic               overrun_clr,
    output logic [ADDR_W-1:0]  rom_addr,
    output logic [1:0]         rom_sel,
    input  logic [DATA_W-1:0]  rom_data,
    output logic [MIX_W-1:0]   mix_out,
    output logic               mix_valid,
    output logic               busy,
    output logic               overrun
);
    localparam int                WCNT_W = $clog2(ROM_LAT + 1);
    localparam logic [VIDX_W-1:0] LAST_V = VIDX_W'(NUM_VOICES - 1);

    // Elaboration-time parameter sanity.
    if (NUM_VOICES < 2 || (NUM_VOICES & (NUM_VOICES - 1)) != 0) begin : g_bad_nv
        $error("NUM_VOICES must be a power of two >= 2");
    end
    if (ROM_LAT < 1) begin : g_bad_lat
        $error("ROM_LAT must be >= 1");
    end
    if (ADDR_W > PHASE_W) begin : g_bad_aw
        $error("ADDR_W must not exceed PHASE_W");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                              state_q, state_d;
    logic [VIDX_W-1:0]                   vidx_q;
    logic [WCNT_W-1:0]                   wcnt_q;
    logic signed [MIX_W-1:0]             acc_q;

    logic [NUM_VOICES-1:0][PHASE_W-1:0]  phase_all;
    logic [NUM_VOICES-1:0][1:0]          shape_all;
    logic [NUM_VOICES-1:0]               en_all;
    logic [NUM_VOICES-1:0]               cfg_hit;
    logic [NUM_VOICES-1:0]               adv;

    logic                                capture;
    logic                                last_voice;
    logic signed [MIX_W-1:0]             sample_ext;

    // Last WAIT cycle of the current voice: rom_data is valid for its address.
    assign capture    = (state_q == WAIT) && (wcnt_q == WCNT_W'(1));
    assign last_voice = (vidx_q == LAST_V);
    assign sample_ext = {{VIDX_W{rom_data[DATA_W-1]}}, rom_data};
    assign busy       = (state_q != IDLE);

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
        assign cfg_hit[i] = cfg_we && (cfg_voice == VIDX_W'(i));
        // Disabled voices are still visited but their phase is frozen.
        assign adv[i]     = capture && (vidx_q == VIDX_W'(i)) && en_all[i];

        wavetable_voice #(.PHASE_W(PHASE_W)) u_voice (
            .clk       (clk),
            .rst_n     (rst_n),
            .cfg_hit   (cfg_hit[i]),
            .cfg_field (cfg_field),
            .cfg_wdata (cfg_wdata),
            .adv       (adv[i]),
            .phase     (phase_all[i]),
            .shape     (shape_all[i]),
            .en        (en_all[i])
        );
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tick) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (capture) state_d = last_voice ? DONE : ISSUE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: voice walk, ROM interface, accumulator, output and overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vidx_q    <= '0;
            wcnt_q    <= '0;
            acc_q     <= '0;
            rom_addr  <= '0;
            rom_sel   <= '0;
            mix_out   <= '0;
            mix_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            mix_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tick) begin
                        acc_q  <= '0;
                        vidx_q <= '0;
                    end
                end
                ISSUE: begin
                    rom_addr <= phase_all[vidx_q][PHASE_W-1 -: ADDR_W];
                    rom_sel  <= shape_all[vidx_q];
                    wcnt_q   <= WCNT_W'(ROM_LAT);
                end
                WAIT: begin
                    wcnt_q <= wcnt_q - WCNT_W'(1);
                    if (capture) begin
                        if (en_all[vidx_q])
                            acc_q <= acc_q + sample_ext;
                        if (!last_voice)
                            vidx_q <= vidx_q + VIDX_W'(1);
                    end
                end
                DONE: begin
                    mix_out   <= acc_q;
                    mix_valid <= 1'b1;
                end
                default: ;
            endcase

            // A dropped tick outranks a same-cycle clear so no overrun is lost.
            if (tick && state_q != IDLE)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_wavetable_voice_scheduler.sv
// Bench for wavetable_voice_scheduler: a table of config writes and frames,
// followed by hand-written sequences for overrun, mid-frame reset and a phase
// load colliding with the voice's own capture edge. Expected mixes are queued
// when the tick is driven and popped by a monitor on mix_valid.
module tb_wavetable_voice_scheduler;
    localparam int NV      = 4;
    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 16;
    localparam int PHASE_W = 32;
    localparam int VIDX_W  = 2;
    localparam int MIX_W   = 18;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               tick = 1'b0;
    logic               cfg_we = 1'b0;
    logic [VIDX_W-1:0]  cfg_voice = '0;
    logic [1:0]         cfg_field = '0;
    logic [PHASE_W-1:0] cfg_wdata = '0;
    logic               overrun_clr = 1'b0;
    logic [ADDR_W-1:0]  rom_addr;
    logic [1:0]         rom_sel;
    logic [DATA_W-1:0]  rom_data;
    logic [MIX_W-1:0]   mix_out;
    logic               mix_valid, busy, overrun;

    // ROM model: either {4'b0, addr} or a constant sample.
    logic               rom_const_mode = 1'b0;
    logic [DATA_W-1:0]  rom_const = '0;
    always_comb rom_data = rom_const_mode ? rom_const : {4'b0, rom_addr};

    wavetable_voice_scheduler #(
        .NUM_VOICES(NV), .ROM_LAT(1), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PHASE_W(PHASE_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .cfg_we(cfg_we), .cfg_voice(cfg_voice),
        .cfg_field(cfg_field), .cfg_wdata(cfg_wdata), .overrun_clr(overrun_clr),
        .rom_addr(rom_addr), .rom_sel(rom_sel), .rom_data(rom_data), .mix_out(mix_out),
        .mix_valid(mix_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_mix   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard of expected mixes and the cycle on which they must appear.
    typedef struct {
        logic [MIX_W-1:0] mix;
        int               due;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        if (rst_n && mix_valid) begin
            exp_t e;
            n_mix++;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_mix_valid: got mix_out=%0h, expected no strobe", mix_out);
            end else begin
                e = sb.pop_front();
                chk("mix_out", mix_out, e.mix);
                chk("mix_valid_cycle", cyc, e.due);
            end
        end
    end

    task automatic cfg_write(input int v, input int f, input logic [31:0] d);
        cfg_we    = 1'b1;
        cfg_voice = VIDX_W'(v);
        cfg_field = 2'(f);
        cfg_wdata = d;
        @(posedge clk); #1;
        cfg_we    = 1'b0;
    endtask

    // One frame: tick, expected mix queued, per-voice select / address checks.
    // tk_edge / cfg_edge: edge (counted from the tick edge) at which an extra
    // tick (optionally with overrun_clr) or a phase load is sampled; -1 = none.
    task automatic run_frame(input logic [MIX_W-1:0] emix, input int chk_v,
                             input logic [ADDR_W-1:0] eaddr, input logic [7:0] esels,
                             input int tk_edge, input bit tk_clr,
                             input int cfg_edge, input int cv, input logic [31:0] cd);
        exp_t e;
        logic [7:0] s;
        s = esels;
        tick = 1'b1;
        @(posedge clk); #1;
        tick  = 1'b0;
        e.mix = emix;
        e.due = cyc + 9;
        sb.push_back(e);
        for (int k = 1; k < 20; k++) begin
            @(posedge clk); #1;
            tick        = (k == tk_edge - 1);
            overrun_clr = tk_clr && (k == tk_edge - 1);
            cfg_we      = (k == cfg_edge - 1);
            cfg_voice   = VIDX_W'(cv);
            cfg_field   = 2'd2;
            cfg_wdata   = cd;
            if (k <= 7 && (k % 2) == 1) begin
                int v;
                v = (k - 1) / 2;
                chk($sformatf("rom_sel_v%0d", v), rom_sel, s[2*v +: 2]);
                if (v == chk_v) chk($sformatf("rom_addr_v%0d", v), rom_addr, eaddr);
            end
            if (k == 1) chk("busy_in_frame", busy, 1);
            if (k == 9) chk("busy_after_frame", busy, 0);
        end
    endtask

    typedef struct {
        bit               is_cfg;
        int               voice;
        int               field;
        logic [31:0]      wdata;
        bit               cmode;
        logic [15:0]      cval;
        logic [MIX_W-1:0] mix;
        int               chk_v;
        logic [11:0]      addr;
        logic [7:0]       sels;
    } vec_t;

    function automatic vec_t mk_cfg(input int v, input int f, input logic [31:0] d);
        vec_t r;
        r = '{default: 0};
        r.is_cfg = 1'b1; r.voice = v; r.field = f; r.wdata = d; r.chk_v = -1;
        return r;
    endfunction

    function automatic vec_t mk_frame(input bit cm, input logic [15:0] cv, input logic [MIX_W-1:0] m,
                                      input int cvv, input logic [11:0] a, input logic [7:0] s);
        vec_t r;
        r = '{default: 0};
        r.cmode = cm; r.cval = cv; r.mix = m; r.chk_v = cvv; r.addr = a; r.sels = s;
        return r;
    endfunction

    vec_t vt[$];
    int   mix_before;

    initial begin
        // Test 1: voice 0 only, shape 2, address ramps 0,1,2.
        vt.push_back(mk_cfg(0, 0, 32'h0010_0000));
        vt.push_back(mk_cfg(0, 1, 32'h6));
        vt.push_back(mk_frame(0, 16'h0, 18'h0, 0, 12'h000, 8'h02));
        vt.push_back(mk_frame(0, 16'h0, 18'h1, 0, 12'h001, 8'h02));
        vt.push_back(mk_frame(0, 16'h0, 18'h2, 0, 12'h002, 8'h02));
        // Test 2: all voices, shapes 0..3, full-scale positive and negative.
        vt.push_back(mk_cfg(0, 1, 32'h4));
        vt.push_back(mk_cfg(1, 1, 32'h5));
        vt.push_back(mk_cfg(2, 1, 32'h6));
        vt.push_back(mk_cfg(3, 1, 32'h7));
        vt.push_back(mk_frame(1, 16'h7FFF, 18'h1FFFC, -1, 12'h0, 8'hE4));
        vt.push_back(mk_frame(1, 16'h8000, 18'h20000, -1, 12'h0, 8'hE4));
        // Test 3: voice 1 alone, phase near the top wraps to address 0.
        vt.push_back(mk_cfg(0, 1, 32'h0));
        vt.push_back(mk_cfg(2, 1, 32'h2));
        vt.push_back(mk_cfg(3, 1, 32'h3));
        vt.push_back(mk_cfg(1, 2, 32'hFFF0_0000));
        vt.push_back(mk_cfg(1, 0, 32'h0010_0000));
        vt.push_back(mk_frame(0, 16'h0, 18'h0FFF, 1, 12'hFFF, 8'hE4));
        vt.push_back(mk_frame(0, 16'h0, 18'h0000, 1, 12'h000, 8'hE4));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_rom_sel", rom_sel, 0);
        chk("rst_mix_out", mix_out, 0);
        chk("rst_mix_valid", mix_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vt[i]) begin
            if (vt[i].is_cfg) begin
                cfg_write(vt[i].voice, vt[i].field, vt[i].wdata);
            end else begin
                rom_const_mode = vt[i].cmode;
                rom_const      = vt[i].cval;
                run_frame(vt[i].mix, vt[i].chk_v, vt[i].addr, vt[i].sels, -1, 1'b0, -1, 0, 32'h0);
            end
        end
        rom_const_mode = 1'b0;

        // Test 4: tick while busy is dropped and flags overrun; set beats clear.
        run_frame(18'h1, 1, 12'h001, 8'hE4, 3, 1'b0, -1, 0, 32'h0);
        chk("overrun_set", overrun, 1);
        run_frame(18'h2, 1, 12'h002, 8'hE4, 3, 1'b1, -1, 0, 32'h0);
        chk("overrun_set_beats_clr", overrun, 1);
        overrun_clr = 1'b1;
        @(posedge clk); #1;
        overrun_clr = 1'b0;
        chk("overrun_cleared", overrun, 0);

        // Test 5: reset mid-frame aborts it and clears all state.
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        @(posedge clk); #1;                 // edge 1
        tick = 1'b1;                        // sampled at edge 3 while busy
        @(posedge clk); #1;                 // edge 2
        @(posedge clk); #1;                 // edge 3
        tick = 1'b0;
        @(posedge clk); #1;                 // edge 4
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_overrun", overrun, 0);
        chk("midrst_mix_out", mix_out, 0);
        chk("midrst_rom_addr", rom_addr, 0);
        chk("midrst_rom_sel", rom_sel, 0);
        mix_before = n_mix;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("midrst_no_mix_valid", n_mix, mix_before);
        cfg_write(0, 0, 32'h0010_0000);
        cfg_write(0, 1, 32'h6);
        run_frame(18'h0, 0, 12'h000, 8'h02, -1, 1'b0, -1, 0, 32'h0);
        run_frame(18'h1, 0, 12'h001, 8'h02, -1, 1'b0, -1, 0, 32'h0);

        // Test 6: phase load on voice 1's capture edge wins over the increment.
        cfg_write(1, 0, 32'h0010_0000);
        cfg_write(1, 1, 32'h5);
        cfg_write(1, 2, 32'h1230_0000);
        run_frame(18'h125, 1, 12'h123, 8'h06, -1, 1'b0, 4, 1, 32'h0);
        run_frame(18'h003, 1, 12'h000, 8'h06, -1, 1'b0, -1, 0, 32'h0);

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/wavetable_voice_scheduler.md
Name: wavetable_voice_scheduler

Overview:
Time-multiplexes one shared four-shape wavetable ROM bank and shape mux among NUM_VOICES oscillator voices. On each sample tick it walks every voice in order: it presents the voice's phase-derived address and shape select, waits out the ROM latency, sums the returned sample, and advances the voice's phase. It then emits one mixed sample per tick. It sits between the host configuration bus / sample-rate tick generator and the wavetable shape-selector ROM bank.

Parameters:
NUM_VOICES, 4, number of voices (power of two, ≥2)
ROM_LAT, 1, clock cycles from rom_addr/rom_sel registered to rom_data valid
ADDR_W, 12, ROM address width
DATA_W, 16, ROM sample width (two's complement)
PHASE_W, 32, phase accumulator / tuning word width
Derived: VIDX_W = clog2(NUM_VOICES); MIX_W = DATA_W + VIDX_W

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
tick  in  1  sample-rate strobe, one cycle wide
cfg_we  in  1  configuration write strobe
cfg_voice  in  VIDX_W  target voice index
cfg_field  in  2  0=tuning word, 1=shape/enable, 2=phase load, 3=reserved (write ignored)
cfg_wdata  in  PHASE_W  write data; field 1 uses [1:0]=shape, [2]=enable
overrun_clr  in  1  clears the overrun flag
rom_addr  out  ADDR_W  address to ROM bank (registered)
rom_sel  out  2  shape select to ROM bank mux (registered)
rom_data  in  DATA_W  selected ROM sample
mix_out  out  MIX_W  signed mixed sample (registered)
mix_valid  out  1  one-cycle strobe: mix_out updated
busy  out  1  frame in progress
overrun  out  1  sticky: tick arrived while busy

Behaviour:
- Reset asserted (low): all phase/ftw/shape/enable registers = 0; rom_addr = 0, rom_sel = 0, mix_out = 0, mix_valid = 0, busy = 0, overrun = 0; FSM = IDLE; accumulator = 0. Assertion mid-frame aborts the frame; no mix_valid.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: when tick = 1, clear accumulator, set voice index v = 0, go to ISSUE.
- ISSUE (1 cycle): register rom_addr = phase[v][PHASE_W-1 -: ADDR_W] and rom_sel = shape[v], then go to WAIT with the wait counter = ROM_LAT.
- WAIT (ROM_LAT cycles): on the final WAIT edge, capture rom_data:
  - accumulator += sign-extend(rom_data) if enable[v], else += 0;
  - phase[v] += ftw[v] mod 2^PHASE_W if enable[v], else phase is held;
  - if v = NUM_VOICES-1 go to DONE, otherwise v += 1 and go to ISSUE.
- DONE (1 cycle): register mix_out = accumulator and pulse mix_valid for one cycle; go to IDLE.
- Latency: mix_valid is high in the cycle after edge NUM_VOICES*(1+ROM_LAT)+1, counted from the edge that samples tick. Defaults give edge 9. The frame is deterministic; disabled voices are still visited.
- busy = (state ≠ IDLE).
- Width: the accumulator is MIX_W signed. The worst-case sum fits exactly, so there is no saturation and no overflow.
- tick while busy: ignored (no queuing); overrun set to 1.
- overrun_clr: clears overrun. If overrun_clr and a set condition occur in the same cycle, set wins.
- Config writes take effect at the edge where cfg_we = 1. Fields, ftw, and phase are readable by the scheduler the next cycle. The ISSUE cycle uses the current register values.
- Phase load on the same edge as that voice's capture update: the loaded value wins and no increment is applied.
- Phase wrap is natural modulo 2^PHASE_W.
- rom_addr and rom_sel hold their last values outside ISSUE.

Test Plan:
1. Reset low then high; ROM model returns sign-extended {4'b0,addr}; voice 0 enabled, ftw=0x00100000, shape=2; ticks at 20-cycle spacing -> mix_valid at edge 9 after each tick, mix_out = 0, 1, 2; rom_sel = 2 during voice-0 ISSUE; all outputs 0 in reset.
2. All 4 voices enabled, shapes 0,1,2,3; ROM model returns 0x7FFF -> rom_sel sequence 0,1,2,3 and mix_out = 0x1FFFC. ROM model returns 0x8000 -> mix_out = 0x20000 (−131072).
3. Voice 1: phase load 0xFFF00000, ftw 0x00100000 -> rom_addr = 0xFFF on the first tick, 0x000 on the second (wrap).
4. Tick reasserted 3 cycles after a tick -> ignored, overrun = 1, single mix_valid. Overrun_clr together with a busy-tick -> overrun stays 1. Overrun_clr alone -> overrun = 0.
5. Reset pulsed low at cycle 4 of a frame -> busy = 0, no mix_valid, phases = 0. Next tick after config reload matches scenario 1 values.
6. Phase load of 0x00000000 to voice 1 on voice 1's capture edge (ftw=0x00100000) -> next frame rom_addr for voice 1 = 0x000.
